ysyx22040413_multi_cycle_cpu: RTL and testbench

YSYX22040413_MULTI_CYCLE_CPU -- requirements
Module: ysyx22040413_multi_cycle_cpu

---
 rtl/ysyx22040413_multi_cycle_cpu.sv | 207 ++++++++++++++++++++
 tb/tb_ysyx22040413_multi_cycle_cpu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx22040413_multi_cycle_cpu.sv
// Multi-cycle RV subset core: FETCH handshakes one instruction and decodes it on the ack cycle,
// EXEC presents the registered retire results and commits them at its closing edge.
module ysyx22040413_multi_cycle_cpu #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'('h8000_0000),
  parameter int unsigned     NREG     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_ack,
  input  logic [31:0]     inst_rdata,
  output logic            commit,
  output logic [XLEN-1:0] commit_pc,
  output logic            rd_w_ena,
  output logic [4:0]      rd_w_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            halt,
  output logic            illegal
);
  localparam int unsigned RIW      = $clog2(NREG);
  localparam logic [5:0]  NREG_LIM = 6'(NREG);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] regs_q [NREG];
  logic            commit_q, commit_d;
  logic            wen_q, wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic            ebreak_q, ebreak_d;
  logic            bad_q, bad_d;
  logic            halt_q, halt_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opc, f7;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic [2:0]      f3;
  logic [XLEN-1:0] rs1_v, rs2_v, imm_i, imm_u, imm_b, imm_j, pc4;
  logic            dec_legal, dec_wen, dec_ebreak, use_rd, use_rs1, use_rs2, jump;
  logic [XLEN-1:0] dec_wdata, dec_npc;

  assign opc   = inst_rdata[6:0];
  assign rd_f  = inst_rdata[11:7];
  assign f3    = inst_rdata[14:12];
  assign rs1_f = inst_rdata[19:15];
  assign rs2_f = inst_rdata[24:20];
  assign f7    = inst_rdata[31:25];

  assign rs1_v = regs_q[rs1_f[RIW-1:0]];
  assign rs2_v = regs_q[rs2_f[RIW-1:0]];
  assign imm_i = XLEN'($signed(inst_rdata[31:20]));
  assign imm_u = XLEN'($signed({inst_rdata[31:12], 12'b0}));
  assign imm_b = XLEN'($signed({inst_rdata[31], inst_rdata[7], inst_rdata[30:25],
                                inst_rdata[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({inst_rdata[31], inst_rdata[19:12], inst_rdata[20],
                                inst_rdata[30:21], 1'b0}));
  assign pc4   = pc_q + XLEN'(4);

  // Decode of the instruction on the bus; only consumed on the ack cycle.
  always_comb begin
    dec_legal  = 1'b1;
    dec_wen    = 1'b0;
    dec_wdata  = '0;
    dec_npc    = pc4;
    dec_ebreak = 1'b0;
    use_rd     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    jump       = 1'b0;
    case (opc)
      7'b0110111: begin use_rd = 1'b1; dec_wen = 1'b1; dec_wdata = imm_u; end
      7'b0010111: begin use_rd = 1'b1; dec_wen = 1'b1; dec_wdata = pc_q + imm_u; end
      7'b0010011: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec_wen = 1'b1;
        dec_wdata = rs1_v + imm_i;
        dec_legal = (f3 == 3'b000);
      end
      7'b0110011: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_wen = 1'b1;
        case ({f7, f3})
          10'b0000000_000: dec_wdata = rs1_v + rs2_v;
          10'b0100000_000: dec_wdata = rs1_v - rs2_v;
          10'b0000000_111: dec_wdata = rs1_v & rs2_v;
          10'b0000000_110: dec_wdata = rs1_v | rs2_v;
          10'b0000000_100: dec_wdata = rs1_v ^ rs2_v;
          10'b0000000_010: dec_wdata = XLEN'($signed(rs1_v) < $signed(rs2_v));
          10'b0000000_011: dec_wdata = XLEN'(rs1_v < rs2_v);
          default:         dec_legal = 1'b0;
        endcase
      end
      7'b1101111: begin
        use_rd = 1'b1; dec_wen = 1'b1; dec_wdata = pc4;
        dec_npc = pc_q + imm_j; jump = 1'b1;
      end
      7'b1100111: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec_wen = 1'b1; dec_wdata = pc4;
        dec_npc = (rs1_v + imm_i) & ~XLEN'(1); jump = 1'b1;
        dec_legal = (f3 == 3'b000);
      end
      7'b1100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f3 == 3'b000)      jump = (rs1_v == rs2_v);
        else if (f3 == 3'b001) jump = (rs1_v != rs2_v);
        else                   dec_legal = 1'b0;
        if (jump) dec_npc = pc_q + imm_b;
      end
      7'b1110011: begin
        if (inst_rdata == 32'h0010_0073) dec_ebreak = 1'b1;
        else                             dec_legal  = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
    // Register indices beyond the implemented file and half-word jump targets are fatal.
    if (use_rd  && ({1'b0, rd_f}  >= NREG_LIM)) dec_legal = 1'b0;
    if (use_rs1 && ({1'b0, rs1_f} >= NREG_LIM)) dec_legal = 1'b0;
    if (use_rs2 && ({1'b0, rs2_f} >= NREG_LIM)) dec_legal = 1'b0;
    if (jump && dec_npc[1]) dec_legal = 1'b0;
    if (rd_f == 5'd0) dec_wen = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    commit_d  = 1'b0;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    npc_d     = npc_q;
    ebreak_d  = ebreak_q;
    bad_d     = bad_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH: begin
        if (inst_ack) begin
          state_d  = EXEC;
          commit_d = dec_legal;
          wen_d    = dec_legal & dec_wen;
          waddr_d  = rd_f;
          wdata_d  = dec_wdata;
          npc_d    = dec_legal ? dec_npc : pc_q;
          ebreak_d = dec_ebreak;
          bad_d    = ~dec_legal;
        end
      end
      EXEC: begin
        state_d   = (bad_q || ebreak_q) ? HALT : FETCH;
        halt_d    = halt_q | ebreak_q;
        illegal_d = illegal_q | bad_q;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      commit_q  <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      npc_q     <= RESET_PC;
      ebreak_q  <= 1'b0;
      bad_q     <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      commit_q  <= commit_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      npc_q     <= npc_d;
      ebreak_q  <= ebreak_d;
      bad_q     <= bad_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
    end
  end

  // Architectural state changes only at the closing edge of EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      for (int unsigned i = 0; i < NREG; i++) regs_q[RIW'(i)] <= '0;
    end else if (state_q == EXEC) begin
      pc_q <= npc_q;
      if (wen_q) regs_q[waddr_q[RIW-1:0]] <= wdata_q;
    end
  end

  assign inst_req  = rst & (state_q == FETCH);
  assign inst_addr = pc_q;
  assign commit    = commit_q;
  assign commit_pc = pc_q;
  assign rd_w_ena  = wen_q;
  assign rd_w_addr = waddr_q;
  assign rd_data   = wdata_q;
  assign halt      = halt_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ysyx22040413_multi_cycle_cpu.sv
// Directed bench: hand-encoded instruction stream on a 64-bit/32-reg core and a 32-bit/16-reg core.
module tb_ysyx22040413_multi_cycle_cpu;
  localparam logic [63:0] ONE  = 64'd1;
  localparam logic [63:0] ZERO = 64'd0;
  localparam logic [63:0] RPC  = 64'h8000_0000;

  logic        clk, rst, ack, sel;
  logic [31:0] rdata;
  logic        ack_m, ack_e;

  logic        req_m, commit_m, wen_m, halt_m, ill_m;
  logic [63:0] addr_m, cpc_m, wdata_m;
  logic [4:0]  waddr_m;
  logic        req_e, commit_e, wen_e, halt_e, ill_e;
  logic [31:0] addr_e, cpc_e, wdata_e;
  logic [4:0]  waddr_e;

  logic [63:0] s_req, s_addr, s_commit, s_cpc, s_wen, s_waddr, s_wdata, s_halt, s_ill;
  int          n_checks, n_errors;

  assign ack_m = ack & ~sel;
  assign ack_e = ack & sel;

  ysyx22040413_multi_cycle_cpu u_dut (
    .clk(clk), .rst(rst), .inst_req(req_m), .inst_addr(addr_m), .inst_ack(ack_m),
    .inst_rdata(rdata), .commit(commit_m), .commit_pc(cpc_m), .rd_w_ena(wen_m),
    .rd_w_addr(waddr_m), .rd_data(wdata_m), .halt(halt_m), .illegal(ill_m)
  );

  ysyx22040413_multi_cycle_cpu #(.XLEN(32), .NREG(16)) u_dut_e (
    .clk(clk), .rst(rst), .inst_req(req_e), .inst_addr(addr_e), .inst_ack(ack_e),
    .inst_rdata(rdata), .commit(commit_e), .commit_pc(cpc_e), .rd_w_ena(wen_e),
    .rd_w_addr(waddr_e), .rd_data(wdata_e), .halt(halt_e), .illegal(ill_e)
  );

  always_comb begin
    if (sel) begin
      s_req = 64'(req_e);   s_addr = 64'(addr_e);  s_commit = 64'(commit_e);
      s_cpc = 64'(cpc_e);   s_wen = 64'(wen_e);    s_waddr = 64'(waddr_e);
      s_wdata = 64'(wdata_e); s_halt = 64'(halt_e); s_ill = 64'(ill_e);
    end else begin
      s_req = 64'(req_m);   s_addr = addr_m;       s_commit = 64'(commit_m);
      s_cpc = cpc_m;        s_wen = 64'(wen_m);    s_waddr = 64'(waddr_m);
      s_wdata = wdata_m;    s_halt = 64'(halt_m);  s_ill = 64'(ill_m);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check_eq({tag, "_rst_req"}, s_req, ZERO);
    check_eq({tag, "_rst_commit"}, s_commit, ZERO);
    check_eq({tag, "_rst_wen"}, s_wen, ZERO);
    check_eq({tag, "_rst_halt"}, s_halt, ZERO);
    check_eq({tag, "_rst_ill"}, s_ill, ZERO);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq({tag, "_rel_req"}, s_req, ONE);
    check_eq({tag, "_rel_addr"}, s_addr, RPC);
  endtask

  // Hold off ack for wait_cyc cycles, then hand over the instruction; returns in EXEC.
  task automatic fetch(input string tag, input logic [31:0] ins, input logic [63:0] pc,
                       input int wait_cyc);
    for (int i = 0; i < wait_cyc; i++) begin
      check_eq({tag, "_wait_req"}, s_req, ONE);
      check_eq({tag, "_wait_addr"}, s_addr, pc);
      check_eq({tag, "_wait_commit"}, s_commit, ZERO);
      tick();
    end
    check_eq({tag, "_req"}, s_req, ONE);
    check_eq({tag, "_addr"}, s_addr, pc);
    ack = 1'b1;
    rdata = ins;
    tick();
    ack = 1'b0;
    rdata = 32'h0;
  endtask

  task automatic retire(input string tag, input logic [63:0] pc, input logic wen,
                        input logic [4:0] wa, input logic [63:0] wd);
    check_eq({tag, "_commit"}, s_commit, ONE);
    check_eq({tag, "_cpc"}, s_cpc, pc);
    check_eq({tag, "_exec_req"}, s_req, ZERO);
    check_eq({tag, "_wen"}, s_wen, 64'(wen));
    if (wen) begin
      check_eq({tag, "_waddr"}, s_waddr, 64'(wa));
      check_eq({tag, "_wdata"}, s_wdata, wd);
    end
    tick();
    check_eq({tag, "_post_commit"}, s_commit, ZERO);
    check_eq({tag, "_post_wen"}, s_wen, ZERO);
  endtask

  task automatic expect_dead(input string tag, input logic [63:0] pc, input logic [63:0] h,
                             input logic [63:0] il);
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq({tag, "_halt"}, s_halt, h);
      check_eq({tag, "_ill"}, s_ill, il);
      check_eq({tag, "_req"}, s_req, ZERO);
      check_eq({tag, "_commit"}, s_commit, ZERO);
      check_eq({tag, "_addr"}, s_addr, pc);
      tick();
    end
    ack = 1'b0;
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] ins, input logic [63:0] pc);
    fetch(tag, ins, pc, 0);
    check_eq({tag, "_commit"}, s_commit, ZERO);
    check_eq({tag, "_wen"}, s_wen, ZERO);
    tick();
    expect_dead(tag, pc, ZERO, ONE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    ack = 1'b0;
    sel = 1'b0;
    rdata = 32'h0;
    tick();
    do_reset("r0");

    fetch("addi1", 32'h0050_0093, 64'h8000_0000, 0);
    retire("addi1", 64'h8000_0000, 1'b1, 5'd1, 64'd5);
    fetch("addim1", 32'hFFF0_0113, 64'h8000_0004, 3);
    retire("addim1", 64'h8000_0004, 1'b1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    fetch("sltu", 32'h0020_3233, 64'h8000_0008, 0);
    retire("sltu", 64'h8000_0008, 1'b1, 5'd4, 64'd1);
    fetch("slt", 32'h0001_22B3, 64'h8000_000C, 1);
    retire("slt", 64'h8000_000C, 1'b1, 5'd5, 64'd1);
    fetch("bne", 32'hFE00_9CE3, 64'h8000_0010, 0);
    retire("bne", 64'h8000_0010, 1'b0, 5'd0, ZERO);
    fetch("beq", 32'hFE00_8CE3, 64'h8000_0008, 0);
    retire("beq", 64'h8000_0008, 1'b0, 5'd0, ZERO);
    fetch("addix0", 32'h0070_0013, 64'h8000_000C, 0);
    retire("addix0", 64'h8000_000C, 1'b0, 5'd0, ZERO);
    fetch("add0", 32'h0000_0133, 64'h8000_0010, 0);
    retire("add0", 64'h8000_0010, 1'b1, 5'd2, ZERO);
    fetch("sub", 32'h4010_0333, 64'h8000_0014, 0);
    retire("sub", 64'h8000_0014, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFB);
    fetch("lui", 32'h8000_03B7, 64'h8000_0018, 0);
    retire("lui", 64'h8000_0018, 1'b1, 5'd7, 64'hFFFF_FFFF_8000_0000);
    fetch("jal", 32'h0080_046F, 64'h8000_001C, 0);
    retire("jal", 64'h8000_001C, 1'b1, 5'd8, 64'h8000_0020);
    fetch("jalr", 32'h0044_0467, 64'h8000_0024, 0);
    retire("jalr", 64'h8000_0024, 1'b1, 5'd8, 64'h8000_0028);
    fetch("xor", 32'h0073_44B3, 64'h8000_0024, 0);
    retire("xor", 64'h8000_0024, 1'b1, 5'd9, 64'h0000_0000_7FFF_FFFB);
    fetch("auipc", 32'h0000_1517, 64'h8000_0028, 0);
    retire("auipc", 64'h8000_0028, 1'b1, 5'd10, 64'h8000_1028);

    // Reset while waiting for ack: x1 must come back as zero.
    check_eq("pre_rst_addr", s_addr, 64'h8000_002C);
    tick();
    do_reset("r1");
    fetch("x1clr", 32'h0000_85B3, 64'h8000_0000, 0);
    retire("x1clr", 64'h8000_0000, 1'b1, 5'd11, ZERO);

    // Reset in EXEC abandons the write of x1.
    fetch("abandon", 32'h0050_0093, 64'h8000_0004, 0);
    check_eq("abandon_commit", s_commit, ONE);
    rst = 1'b0;
    #1;
    check_eq("abandon_rst_commit", s_commit, ZERO);
    check_eq("abandon_rst_wen", s_wen, ZERO);
    tick();
    rst = 1'b1;
    #1;
    fetch("x1still0", 32'h0000_85B3, 64'h8000_0000, 0);
    retire("x1still0", 64'h8000_0000, 1'b1, 5'd11, ZERO);

    run_illegal("badop", 32'h0000_007F, 64'h8000_0004);
    do_reset("r2");
    run_illegal("misal", 32'h0020_006F, 64'h8000_0000);
    do_reset("r3");
    fetch("ebreak", 32'h0010_0073, 64'h8000_0000, 0);
    retire("ebreak", 64'h8000_0000, 1'b0, 5'd0, ZERO);
    expect_dead("halted", 64'h8000_0004, ONE, ZERO);

    sel = 1'b1;
    do_reset("r4");
    fetch("e_addim1", 32'hFFF0_0193, 64'h8000_0000, 0);
    retire("e_addim1", 64'h8000_0000, 1'b1, 5'd3, 64'h0000_0000_FFFF_FFFF);
    fetch("e_sltu", 32'h0030_3233, 64'h8000_0004, 0);
    retire("e_sltu", 64'h8000_0004, 1'b1, 5'd4, 64'd1);
    run_illegal("e_rd16", 32'h0010_0813, 64'h8000_0008);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
